// File: rtl/out_spike_buf_if.sv
// Spike packet injection port between the output spike buffer and the router.
// The buffer side is the master: it presents a neuron index with a valid flag
// and the router answers with ready.
interface out_spike_buf_if #(
    parameter int NEURON_CNT_BIT_WIDTH = 8
) ();

    logic                            pkt_valid;
    logic                            pkt_ready;
    logic [NEURON_CNT_BIT_WIDTH-1:0] pkt_neuron;

    modport master (
        output pkt_valid,
        output pkt_neuron,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_neuron,
        output pkt_ready
    );

endinterface

// File: rtl/out_spike_buf.sv
// Output spike buffer: neuron units write fired spikes into a ping-pong bitmap
// during a timestep. On start_i the banks swap and the frozen bank is scanned
// in ascending neuron order. Each set bit is sent as one packet (the neuron
// index) and cleared once the router accepts it, so the frozen bank is all
// zeros by the time it becomes the write bank again.
module out_spike_buf #(
    parameter int NUM_NEURONS          = 256,
    parameter int NEURON_CNT_BIT_WIDTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    input  logic                            wrEn_spike_i,
    input  logic [NEURON_CNT_BIT_WIDTH-1:0] NeuronAddr_i,
    input  logic                            spike_i,
    out_spike_buf_if.master                 pkt,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [NEURON_CNT_BIT_WIDTH:0]   spikeCnt_o,
    output logic                            startErr_o
);

    localparam int W = NEURON_CNT_BIT_WIDTH;
    localparam logic [W-1:0] LAST_IDX = W'(NUM_NEURONS - 1);
    localparam logic [W-1:0] IDX_ONE  = W'(1);
    localparam logic [W:0]   CNT_ONE  = (W+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_r;
    logic [NUM_NEURONS-1:0] bank0_r;
    logic [NUM_NEURONS-1:0] bank1_r;
    logic                 wrBank_r;
    logic [W-1:0]         scanIdx_r;
    logic                 pktValid_r;
    logic [W-1:0]         pktNeuron_r;
    logic                 busy_r;
    logic                 done_r;
    logic [W:0]           spikeCnt_r;
    logic                 startErr_r;
    logic                 scanBit_s;
    logic                 handshake_s;

    // Bit under the scan pointer in the frozen bank (the one not being written).
    always_comb begin
        scanBit_s = 1'b0;
        if (wrBank_r) begin
            scanBit_s = bank0_r[scanIdx_r];
        end else begin
            scanBit_s = bank1_r[scanIdx_r];
        end
    end

    assign handshake_s = pktValid_r & pkt.pkt_ready;

    // Bank storage, write port, scan/send state machine and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= IDLE;
            bank0_r     <= {NUM_NEURONS{1'b0}};
            bank1_r     <= {NUM_NEURONS{1'b0}};
            wrBank_r    <= 1'b0;
            scanIdx_r   <= {W{1'b0}};
            pktValid_r  <= 1'b0;
            pktNeuron_r <= {W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            spikeCnt_r  <= {(W+1){1'b0}};
            startErr_r  <= 1'b0;
        end else begin
            // The write bank is never the scan bank, so this cannot collide
            // with the clear below. A write coinciding with start lands in the
            // old write bank and is therefore part of the scan.
            if (wrEn_spike_i) begin
                if (wrBank_r) begin
                    bank1_r[NeuronAddr_i] <= spike_i;
                end else begin
                    bank0_r[NeuronAddr_i] <= spike_i;
                end
            end

            startErr_r <= start_i && (state_r != IDLE);

            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        wrBank_r   <= ~wrBank_r;
                        scanIdx_r  <= {W{1'b0}};
                        spikeCnt_r <= {(W+1){1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= SCAN;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scanBit_s) begin
                        pktValid_r  <= 1'b1;
                        pktNeuron_r <= scanIdx_r;
                        state_r     <= SEND;
                    end else if (scanIdx_r == LAST_IDX) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        scanIdx_r <= scanIdx_r + IDX_ONE;
                    end
                end
                SEND: begin
                    if (handshake_s) begin
                        if (wrBank_r) begin
                            bank0_r[scanIdx_r] <= 1'b0;
                        end else begin
                            bank1_r[scanIdx_r] <= 1'b0;
                        end
                        spikeCnt_r <= spikeCnt_r + CNT_ONE;
                        pktValid_r <= 1'b0;
                        if (scanIdx_r == LAST_IDX) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            scanIdx_r <= scanIdx_r + IDX_ONE;
                            state_r   <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    pktValid_r <= 1'b0;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign pkt.pkt_valid  = pktValid_r;
    assign pkt.pkt_neuron = pktNeuron_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign spikeCnt_o     = spikeCnt_r;
    assign startErr_o     = startErr_r;

endmodule

// File: tb/tb_out_spike_buf.sv
// Bench for out_spike_buf with 16 neurons: a table of scan scenarios plus a
// hand-written reset-mid-packet sequence. Expected packets are queued from the
// table bitmap when a scan is started and popped as the DUT hands them off.
module tb_out_spike_buf;

    localparam int NN = 16;
    localparam int W  = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         wrEn;
    logic [W-1:0] addr;
    logic         spike;
    logic         busy;
    logic         done;
    logic [W:0]   cnt;
    logic         startErr;

    out_spike_buf_if #(.NEURON_CNT_BIT_WIDTH(W)) pktIf ();

    out_spike_buf #(
        .NUM_NEURONS          (NN),
        .NEURON_CNT_BIT_WIDTH (W)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .wrEn_spike_i (wrEn),
        .NeuronAddr_i (addr),
        .spike_i      (spike),
        .pkt          (pktIf.master),
        .busy_o       (busy),
        .done_o       (done),
        .spikeCnt_o   (cnt),
        .startErr_o   (startErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pre;      // bits written before start
        logic [15:0] mid;      // bits written into the new bank during the scan
        logic [15:0] expBits;  // packets expected from this scan
        int          stallN;   // neuron whose packet sees ready held low
        int          stallCyc; // how many cycles ready is held low
        int          errCyc;   // scan cycle at which a stray start is pulsed
        int          expCnt;
        bit          chkLat;
    } vec_t;

    int nChecks = 0;
    int nPass   = 0;
    int expQ[$];
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] pre, input logic [15:0] mid,
                                input logic [15:0] expBits, input int stallN,
                                input int stallCyc, input int errCyc,
                                input int expCnt, input bit chkLat);
        vec_t v;
        v.pre = pre; v.mid = mid; v.expBits = expBits;
        v.stallN = stallN; v.stallCyc = stallCyc; v.errCyc = errCyc;
        v.expCnt = expCnt; v.chkLat = chkLat;
        return v;
    endfunction

    task automatic write_bit(input int a);
        wrEn = 1'b1; addr = W'(a); spike = 1'b1;
        @(posedge clk); #1;
        wrEn = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int cyc, doneCyc, runLen, firstN, stallLeft, errSeen, expN;
        int midList[$];
        for (int i = 0; i < NN; i++) if (v.pre[i]) write_bit(i);
        for (int i = 0; i < NN; i++) if (v.mid[i]) midList.push_back(i);
        for (int i = 0; i < NN; i++) if (v.expBits[i]) expQ.push_back(i);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; doneCyc = -1; runLen = 0; firstN = -1; stallLeft = -1; errSeen = 0;
        while (doneCyc < 0 && cyc < 400) begin
            wrEn = 1'b0;
            if (cyc >= 2 && midList.size() > 0) begin
                addr = W'(midList.pop_front()); spike = 1'b1; wrEn = 1'b1;
            end
            start = (cyc == v.errCyc);
            if (pktIf.pkt_valid && int'(pktIf.pkt_neuron) == v.stallN && stallLeft < 0)
                stallLeft = v.stallCyc;
            if (stallLeft > 0) begin
                pktIf.pkt_ready = 1'b0; stallLeft--;
            end else begin
                pktIf.pkt_ready = 1'b1;
            end
            @(negedge clk);
            if (startErr) errSeen++;
            if (pktIf.pkt_valid) begin
                if (runLen == 0) firstN = int'(pktIf.pkt_neuron);
                else check("pkt_stable", int'(pktIf.pkt_neuron), firstN);
                runLen++;
            end
            if (pktIf.pkt_valid && pktIf.pkt_ready) begin
                check("pkt_expected", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    expN = expQ.pop_front();
                    check("pkt_neuron", int'(pktIf.pkt_neuron), expN);
                end
                check("pkt_valid_len", runLen,
                      (int'(pktIf.pkt_neuron) == v.stallN) ? v.stallCyc + 1 : 1);
                runLen = 0;
            end
            if (done) begin
                doneCyc = cyc;
                check("busy_during_done", int'(busy), 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; wrEn = 1'b0; pktIf.pkt_ready = 1'b1;
        check("done_seen", int'(doneCyc >= 0), 1);
        if (v.chkLat) check("done_latency", doneCyc, NN);
        check("spike_cnt", int'(cnt), v.expCnt);
        check("queue_drained", expQ.size(), 0);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("start_err_pulses", errSeen, (v.errCyc >= 0) ? 1 : 0);
        if (expQ.size() != 0) $display("note: vector %0d left packets pending", vi);
        expQ.delete();
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waitCyc;
        vecs[0] = mk(16'h0000, 16'h0000, 16'h0000, -1, 0, -1, 0, 1'b1);
        vecs[1] = mk(16'h8088, 16'h0000, 16'h8088, -1, 0, -1, 3, 1'b0);
        vecs[2] = mk(16'h8088, 16'h0000, 16'h8088,  7, 5, -1, 3, 1'b0);
        vecs[3] = mk(16'h0004, 16'h0204, 16'h0004, -1, 0, -1, 1, 1'b0);
        vecs[4] = mk(16'h0000, 16'h0000, 16'h0204, -1, 0, -1, 2, 1'b0);
        vecs[5] = mk(16'h0000, 16'h0000, 16'h0000, -1, 0, -1, 0, 1'b1);
        vecs[6] = mk(16'h0412, 16'h0000, 16'h0412, -1, 0,  5, 3, 1'b0);
        vecs[7] = mk(16'h0000, 16'h0000, 16'h0000, -1, 0, -1, 0, 1'b0);
        vecs[8] = mk(16'hFFFF, 16'h0000, 16'hFFFF, -1, 0, -1, 16, 1'b0);
        vecs[9] = mk(16'h8001, 16'h0000, 16'h8001,  0, 2, -1, 2, 1'b0);

        rst_n = 1'b0; start = 1'b0; wrEn = 1'b0; addr = '0; spike = 1'b0;
        pktIf.pkt_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(pktIf.pkt_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cnt", int'(cnt), 0);
        check("rst_err", int'(startErr), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset while a packet is being offered: everything drops at once.
        pktIf.pkt_ready = 1'b0;
        write_bit(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        write_bit(8);
        waitCyc = 0;
        while (!pktIf.pkt_valid && waitCyc < 40) begin
            @(negedge clk);
            waitCyc++;
        end
        check("rst_pre_valid", int'(pktIf.pkt_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", int'(pktIf.pkt_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_cnt", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pktIf.pkt_ready = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], 10);
        run_vec(vecs[5], 11);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/out_spike_buf.md
Name: out_spike_buf

Overview:
- Transmit-side counterpart of the core's input spike buffer.
- Neuron units write their output spikes into a ping-pong spike bitmap, addressed by neuron index, during a timestep.
- On start_i the banks swap. The block then scans the frozen bank and emits one spike packet (neuron index) per set bit to the router injection port over a valid/ready handshake.
- Each sent bit is cleared. The block pulses done_o when the scan completes.

Parameters:
- NUM_NEURONS, 256, number of neurons (bitmap depth per bank).
- NEURON_CNT_BIT_WIDTH, 8, width of neuron index (log2 NUM_NEURONS).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  timestep boundary; swap banks and begin scan.
- wrEn_spike_i  in  1  write strobe for the neuron spike bit.
- NeuronAddr_i  in  NEURON_CNT_BIT_WIDTH  neuron index to write.
- spike_i  in  1  spike value written (1 = fired, 0 = clear).
- pkt_ready_i  in  1  router accepts packet.
- pkt_valid_o  out  1  packet valid.
- pkt_neuron_o  out  NEURON_CNT_BIT_WIDTH  neuron index of the spike packet.
- busy_o  out  1  scan in progress (state != IDLE).
- done_o  out  1  one-cycle pulse at scan end.
- spikeCnt_o  out  NEURON_CNT_BIT_WIDTH+1  number of packets sent in the last scan.
- startErr_o  out  1  one-cycle pulse when start_i arrives while busy.

Behaviour:
- Reset (async):
  - both banks all 0; wrBank=0; state IDLE; idx=0.
  - all outputs 0.
- Write port:
  - wrEn_spike_i=1 at an edge writes spike_i into bank[wrBank][NeuronAddr_i].
  - Allowed in any state.
  - Never touches the scan bank (scan bank = ~wrBank after a swap), so write and scan-clear never collide.
- State machine: IDLE, SCAN, SEND, DONE.
- IDLE:
  - start_i=1 -> wrBank<=~wrBank, idx<=0, spikeCnt_o<=0, go to SCAN.
  - A write in the same cycle as start goes to the old wrBank, i.e. it is included in the scan.
- SCAN (one bit per cycle) examines bank[~wrBank][idx]:
  - bit=1 -> pkt_valid_o<=1, pkt_neuron_o<=idx, go to SEND.
  - bit=0 and idx=NUM_NEURONS-1 -> go to DONE.
  - bit=0 otherwise -> idx<=idx+1.
- SEND:
  - pkt_valid_o and pkt_neuron_o are held stable until pkt_valid_o & pkt_ready_i at an edge.
  - On that handshake: clear the bit, spikeCnt_o<=spikeCnt_o+1, pkt_valid_o<=0.
  - After the handshake: idx=NUM_NEURONS-1 -> DONE; else idx<=idx+1 and go to SCAN.
  - pkt_ready_i has no effect while pkt_valid_o=0.
- DONE: done_o=1 for exactly this cycle, then IDLE. spikeCnt_o holds until the next start.
- Latency:
  - Start sampled at edge 0.
  - Empty bank: done_o high in the cycle after edge NUM_NEURONS; busy_o low after edge NUM_NEURONS+1.
  - Each set bit adds 1 cycle plus handshake wait (min 2 cycles per packet with ready tied high).
- start_i while state != IDLE: ignored (no swap, scan continues); startErr_o pulses 1 cycle.
- Packets are emitted in ascending neuron order; no duplicates; exactly one packet per set bit.
- After a scan completes, the scan bank is all zeros and is ready to become the next write bank.
- Reset mid-scan: immediate return to reset state. Banks are cleared; any packet in flight is dropped (pkt_valid_o deasserts asynchronously).

Test Plan (NUM_NEURONS=16, NEURON_CNT_BIT_WIDTH=4):
- Reset, then start with no writes -> no pkt_valid_o; done_o pulses in the cycle after edge 16; spikeCnt_o=0.
- Write spikes at 3, 7, 15; start; pkt_ready_i=1 -> packets 3, 7, 15 in order, each valid exactly 1 cycle; done_o pulses once; spikeCnt_o=3.
- Same as previous with pkt_ready_i low for 5 cycles on packet 7 -> pkt_valid_o and pkt_neuron_o=7 stable for 6 cycles; no loss or duplication; spikeCnt_o=3.
- During a scan of {2}, write neuron 2 and 9 into the new bank, then a second start after done_o -> second scan emits 2, 9; a third start emits nothing (banks cleared).
- Pulse start_i mid-scan -> startErr_o 1-cycle pulse; current scan result is unchanged; no bank swap.
- Assert rst_n_i low while pkt_valid_o=1 -> all outputs 0 immediately; a following start with no writes emits no packets.
